imem_loader: RTL and testbench

Byte-stream program loader: the write side of the instruction memory the CPU fetches from.
- Accepts a framed byte stream: 16-bit word count header, then little-endian 32-bit words.
- Assembles each word and writes it into instruction memory at consecutive addresses from 0.
- Holds the CPU in stall while loading; sits between a byte source (UART RX / switch-stepped input) and the IM write port.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 36 +++
 rtl/imem_loader_byte_to_word.sv | 41 ++++
 rtl/imem_loader.sv | 168 ++++++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the byte-stream instruction-memory loader:
// FSM state encoding, header width and the byte-accepting state set.
package imem_loader_pkg;

   localparam int HDR_W  = 16;
   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_HDR_LO = 3'd1,
      ST_HDR_HI = 3'd2,
      ST_BYTES  = 3'd3,
      ST_WRITE  = 3'd4,
      ST_CHK    = 3'd5,
      ST_DONE   = 3'd6,
      ST_ERR    = 3'd7
   } state_t;

   // States in which the loader presents in_ready to the byte source.
   function automatic logic accepts_bytes(input state_t s);
      return (s == ST_HDR_LO) || (s == ST_HDR_HI) || (s == ST_BYTES) || (s == ST_CHK);
   endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input, IM write port and status bundle of the loader.
interface imem_loader_if
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 4
);
   // Byte handshake: a byte moves on a rising clk edge where in_valid and
   // in_ready are both 1; in_data must be stable while in_valid is high, and
   // in_ready never depends combinationally on in_valid.
   logic              start;
   logic [7:0]        in_data;
   logic              in_valid;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic              cpu_stall;
   logic              busy;
   logic              done;
   logic              err;
   logic [ADDR_W:0]   words_loaded;
   state_t            dbg_state;

   modport master (
      output start, in_data, in_valid,
      input  in_ready, mem_we, mem_addr, mem_wdata, cpu_stall, busy, done, err,
             words_loaded, dbg_state
   );

   modport slave (
      input  start, in_data, in_valid,
      output in_ready, mem_we, mem_addr, mem_wdata, cpu_stall, busy, done, err,
             words_loaded, dbg_state
   );

endinterface

// File: rtl/imem_loader_byte_to_word.sv
// Little-endian 4-byte assembler: byte k lands in word[8k+7:8k]; word_valid
// flags the cycle the fourth byte arrives, with word_next already complete.
module byte_to_word (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_in,
   output logic [31:0] word_next,
   output logic        word_valid
);

   logic [23:0] word_q, word_d;
   logic [1:0]  idx_q, idx_d;

   // Only the three earlier bytes are stored; the fourth is merged on the fly.
   always_comb begin
      word_next  = {byte_in, word_q};
      word_valid = byte_valid && (idx_q == 2'd3);
      word_d     = word_q;
      idx_d      = idx_q;
      if (clear) begin
         word_d = '0;
         idx_d  = '0;
      end else if (byte_valid) begin
         word_d = word_next[31:8];
         idx_d  = idx_q + 2'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q <= '0;
         idx_q  <= '0;
      end else begin
         word_q <= word_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Program loader: parses a counted byte frame and writes words to IM from
// address 0 while stalling the CPU. CHECKSUM_EN adds a trailing XOR byte check.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 32
) (
   input logic         clk,
   input logic         rst,
   imem_loader_if.slave bus
);

   localparam int DEPTH = 2 ** ADDR_W;
`ifdef CHECKSUM_EN
   localparam state_t END_ST = ST_CHK;
`else
   localparam state_t END_ST = ST_DONE;
`endif

   state_t              state_q, state_d;
   logic [HDR_W-1:0]    count_q, count_d;
   logic [HDR_W-1:0]    hdr_full;
   logic [ADDR_W:0]     wl_q, wl_d, wl_inc;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                in_ready_q, in_ready_d;
   logic                we_q, we_d;
   logic                done_q, done_d;
   logic                stall_q, stall_d;
   logic                err_q, err_d;
   logic                xfer;
   logic                b2w_clear;
   logic                b2w_valid;
   logic                word_valid;
   logic [31:0]         word_next;
`ifdef CHECKSUM_EN
   logic [BYTE_W-1:0]   csum_q, csum_d;
`endif

   assign xfer      = bus.in_valid && in_ready_q;
   assign b2w_valid = xfer && (state_q == ST_BYTES);
   assign hdr_full  = {bus.in_data, count_q[7:0]};
   assign wl_inc    = wl_q + 1'b1;

   byte_to_word u_b2w (
      .clk       (clk),
      .rst       (rst),
      .clear     (b2w_clear),
      .byte_valid(b2w_valid),
      .byte_in   (bus.in_data),
      .word_next (word_next),
      .word_valid(word_valid)
   );

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      wl_d      = wl_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      err_d     = err_q;
      b2w_clear = 1'b0;
`ifdef CHECKSUM_EN
      csum_d    = csum_q;
      if (xfer && (state_q != ST_CHK)) csum_d = csum_q ^ bus.in_data;
`endif
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               err_d     = 1'b0;
               wl_d      = '0;
               count_d   = '0;
               b2w_clear = 1'b1;
`ifdef CHECKSUM_EN
               csum_d    = '0;
`endif
               state_d   = ST_HDR_LO;
            end
         end
         ST_HDR_LO: begin
            if (xfer) begin
               count_d[7:0] = bus.in_data;
               state_d      = ST_HDR_HI;
            end
         end
         ST_HDR_HI: begin
            if (xfer) begin
               count_d[15:8] = bus.in_data;
               if (hdr_full == '0)                    state_d = END_ST;
               else if (hdr_full > HDR_W'(DEPTH))     state_d = ST_ERR;
               else                                   state_d = ST_BYTES;
            end
         end
         ST_BYTES: begin
            // Launch the write with the word completed by this byte.
            if (word_valid) begin
               addr_d  = wl_q[ADDR_W-1:0];
               wdata_d = word_next;
               state_d = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wl_d    = wl_inc;
            state_d = (HDR_W'(wl_inc) == count_q) ? END_ST : ST_BYTES;
         end
`ifdef CHECKSUM_EN
         ST_CHK: begin
            if (xfer) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
         end
`endif
         ST_DONE: state_d = ST_IDLE;
         ST_ERR:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered views of the next state.
      in_ready_d = accepts_bytes(state_d);
      we_d       = (state_d == ST_WRITE);
      done_d     = (state_d == ST_DONE);
      stall_d    = (state_d != ST_IDLE);
      if (state_d == ST_ERR) err_d = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         wl_q       <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         in_ready_q <= 1'b0;
         we_q       <= 1'b0;
         done_q     <= 1'b0;
         stall_q    <= 1'b0;
         err_q      <= 1'b0;
`ifdef CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wl_q       <= wl_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         in_ready_q <= in_ready_d;
         we_q       <= we_d;
         done_q     <= done_d;
         stall_q    <= stall_d;
         err_q      <= err_d;
`ifdef CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign bus.in_ready     = in_ready_q;
   assign bus.mem_we       = we_q;
   assign bus.mem_addr     = addr_q;
   assign bus.mem_wdata    = wdata_q;
   assign bus.cpu_stall    = stall_q;
   assign bus.busy         = stall_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.words_loaded = wl_q;
   assign bus.dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-plus-random bench for imem_loader: frames are built from word lists,
// expected IM writes and status come from a frame-level reference model.
module tb_imem_loader;
   import imem_loader_pkg::*;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 16;
   localparam int W      = ADDR_W + 32;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int errors   = 0;
   int checks   = 0;
   int cyc      = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int stall_bad = 0;
   logic [W-1:0]  exp_q[$];
   logic [W-1:0]  obs_q[$];
   logic [31:0]   frame_words[$];
   logic [31:0]   im [DEPTH];

   always @(posedge clk) cyc++;

   // IM model and event monitor, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.mem_we) begin
            obs_q.push_back({bus.mem_addr, bus.mem_wdata});
            im[bus.mem_addr] = bus.mem_wdata;
         end
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
            if (!bus.cpu_stall) stall_bad++;
         end
         if (bus.busy !== bus.cpu_stall) stall_bad++;
      end
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("stall_after_start", {62'd0, bus.cpu_stall, bus.err}, 64'h2);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap_max);
      int tmo;
      repeat ($urandom_range(0, gap_max)) @(negedge clk);
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      tmo = 0;
      while (bus.in_ready !== 1'b1 && tmo < 50) begin
         @(negedge clk);
         tmo++;
      end
      if (tmo >= 50) check("in_ready_timeout", 64'(tmo), 64'd0);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = $urandom_range(0, 255);
   endtask

   // Reference: a frame of cnt words writes words 0..cnt-1 to addresses 0..cnt-1
   // unless cnt exceeds DEPTH, in which case nothing is written and err is set.
   task automatic run_frame(input logic [15:0] cnt, input int gap_max,
                            input logic corrupt, input logic lat_chk);
      int n_exp, d0, hdr_cyc, tmo, extra;
      logic exp_err;
      logic [7:0] csum, b;
      n_exp   = (cnt <= 16'(DEPTH)) ? int'(cnt) : 0;
      exp_err = (cnt > 16'(DEPTH));
      extra   = 0;
      csum    = cnt[7:0] ^ cnt[15:8];
      obs_q.delete();
      exp_q.delete();
      for (int i = 0; i < n_exp; i++) exp_q.push_back({ADDR_W'(i), frame_words[i]});
      d0 = done_cnt;
      pulse_start();
      hdr_cyc = cyc;
      send_byte(cnt[7:0], gap_max);
      send_byte(cnt[15:8], gap_max);
      for (int i = 0; i < n_exp; i++) begin
         for (int k = 0; k < 4; k++) begin
            b = frame_words[i][8*k +: 8];
            csum ^= b;
            send_byte(b, gap_max);
         end
      end
`ifdef CHECKSUM_EN
      if (!exp_err) begin
         send_byte(corrupt ? ~csum : csum, gap_max);
         exp_err = corrupt;
         extra   = 1;
      end
`else
      if (corrupt) extra = 0;
`endif
      tmo = 0;
      while (bus.cpu_stall === 1'b1 && tmo < 40) begin
         @(negedge clk);
         tmo++;
      end
      check("frame_end_timeout", 64'(tmo >= 40), 64'd0);
      check("write_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++)
         if (i < obs_q.size()) check($sformatf("write[%0d]", i), 64'(obs_q[i]), 64'(exp_q[i]));
      check("done_pulses", 64'(done_cnt - d0), exp_err ? 64'd0 : 64'd1);
      check("err_flag", {63'd0, bus.err}, {63'd0, exp_err});
      check("words_loaded", 64'(bus.words_loaded), 64'(n_exp));
      check("stall_consistency", 64'(stall_bad), 64'd0);
      if (lat_chk && !exp_err)
         check("latency", 64'(done_cyc - hdr_cyc), 64'(2 + 5 * n_exp + extra));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bus.start    = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      for (int i = 0; i < DEPTH; i++) im[i] = 32'h0;
      #1;
      check("reset_outputs",
            {bus.in_ready, bus.mem_we, 4'(bus.mem_addr), bus.mem_wdata, bus.cpu_stall,
             bus.busy, bus.done, bus.err, 5'(bus.words_loaded)}, 64'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      // Two-word program with full-rate input, latency checked.
      frame_words = '{32'h00100513, 32'h00200593};
      run_frame(16'd2, 0, 1'b0, 1'b1);

      // Zero-length frame.
      frame_words.delete();
      run_frame(16'd0, 0, 1'b0, 1'b1);

      // Oversize header: error, no writes; next start clears err.
      run_frame(16'd17, 0, 1'b0, 1'b0);
      check("err_sticky_idle", {63'd0, bus.err}, 64'd1);
      run_frame(16'h0100, 0, 1'b0, 1'b0);

      // Full depth with 0x1000_0000 + i.
      frame_words.delete();
      for (int i = 0; i < DEPTH; i++) frame_words.push_back(32'h1000_0000 + 32'(i));
      run_frame(16'd16, 0, 1'b0, 1'b1);
      check("full_depth_last", {32'd0, im[DEPTH-1]}, 64'h1000_000F);

      // Random words with random in_valid gaps.
      for (int r = 0; r < 3; r++) begin
         n = $urandom_range(1, DEPTH);
         frame_words.delete();
         for (int i = 0; i < n; i++) frame_words.push_back($urandom);
         run_frame(16'(n), 3, 1'b0, 1'b0);
      end

      // Reset after the 2nd byte of word 1.
      frame_words = '{32'hCAFE_F00D, 32'h1234_5678};
      obs_q.delete();
      pulse_start();
      send_byte(8'h02, 1);
      send_byte(8'h00, 1);
      for (int k = 0; k < 4; k++) send_byte(frame_words[0][8*k +: 8], 1);
      for (int k = 0; k < 2; k++) send_byte(frame_words[1][8*k +: 8], 1);
      rst = 1'b1;
      #1;
      check("mid_frame_reset_outputs",
            {bus.in_ready, bus.mem_we, 4'(bus.mem_addr), bus.mem_wdata, bus.cpu_stall,
             bus.busy, bus.done, bus.err, 5'(bus.words_loaded)}, 64'd0);
      check("mid_frame_writes", 64'(obs_q.size()), 64'd1);
      check("addr0_retained", {32'd0, im[0]}, 64'hCAFE_F00D);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      frame_words = '{32'hA5A5_0001};
      run_frame(16'd1, 2, 1'b0, 1'b0);

`ifdef CHECKSUM_EN
      frame_words = '{32'hDDCC_BBAA};
      run_frame(16'd1, 0, 1'b0, 1'b1);
      run_frame(16'd1, 0, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
